// File: rtl/toggle_reg_bank.sv
// toggle_reg_bank: a WIDTH-bit register that can toggle selected bits, count
// up or down (wrapping or saturating at the boundaries) or parallel-load.
// It also produces a one-cycle terminal-count pulse (tc) and a sticky
// boundary flag (ovf). Every output is registered.
module toggle_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             ovf_next;

  // Next-state decode: clr beats the enable, and the enable beats the mode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    q_next   = q;
    tc_next  = 1'b0;
    ovf_next = ovf;
    if (clr) begin
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (en) begin
      unique case (mode_e'(mode))
        MODE_TOGGLE: q_next = q ^ t;
        MODE_UP: begin
          if (q == ALL_ONES) begin
            tc_next  = 1'b1;
            ovf_next = 1'b1;
            if (!SATURATE) q_next = '0;
          end else begin
            q_next = q + ONE;
          end
        end
        MODE_DOWN: begin
          if (q == '0) begin
            tc_next  = 1'b1;
            ovf_next = 1'b1;
            if (!SATURATE) q_next = ALL_ONES;
          end else begin
            q_next = q - ONE;
          end
        end
        MODE_LOAD: begin
          q_next   = d;
          ovf_next = 1'b0;
        end
        default: q_next = q;
      endcase
    end
  end

  // State register. Reset is asynchronous, and it wins over any edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= RESET_VAL;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for state so that every register
      // samples the pre-edge values, whatever the statement order.
      q   <= q_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

endmodule
